forwarding_hazard_unit: RTL

- Sequential hazard/forwarding controller for the IF/DOF/EX/WB pipeline; it resolves the data hazards that the `data_forwarding` bench injects.
- Keeps its own per-stage copy of in-flight destination tags (EX slot, WB slot), fed from DOF decode.
- Drives the operand-forwarding selects for `muxA`/`muxB` and the stall/bubble controls for the PC, the IF/DOF register and the DOF/EX register.
- Inserts a load-use stall of `LOAD_STALL_CYCLES` cycles.

---
 rtl/forwarding_hazard_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard control for the IF/DOF/EX/WB pipeline.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STAT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dof_valid,
  input  logic [REG_ADDR_W-1:0] dof_aa,
  input  logic [REG_ADDR_W-1:0] dof_ba,
  input  logic                  dof_use_a,
  input  logic                  dof_use_b,
  input  logic [REG_ADDR_W-1:0] dof_da,
  input  logic                  dof_rw,
  input  logic                  dof_md,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_count,
  output logic [STAT_W-1:0]     fwd_count
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] da;
    logic                  rw;
    logic                  md;
  } slot_t;

  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);

  slot_t      ex_slot;
  slot_t      wb_slot;
  logic [2:0] stall_cnt;

  logic a_hit_ex, b_hit_ex, a_hit_wb, b_hit_wb;
  logic hazard;

  // R0 is hard-wired zero, so it can never be a forwarding or stall source.
  function automatic logic src_hit(input slot_t s, input logic [REG_ADDR_W-1:0] src,
                                   input logic use_bit);
    return s.valid && s.rw && (s.da == src) && (src != '0) && use_bit;
  endfunction

  always_comb begin
    a_hit_ex = src_hit(ex_slot, dof_aa, dof_use_a);
    b_hit_ex = src_hit(ex_slot, dof_ba, dof_use_b);
    a_hit_wb = src_hit(wb_slot, dof_aa, dof_use_a);
    b_hit_wb = src_hit(wb_slot, dof_ba, dof_use_b);
    hazard   = dof_valid && ex_slot.md && (a_hit_ex || b_hit_ex);
    stall    = hazard || (stall_cnt != 3'd0);
    bubble   = stall;
  end

  // EX wins over WB because it carries the newer value; a load in EX cannot
  // forward yet, so it falls through to the WB check (stall covers it).
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (a_hit_ex && !ex_slot.md) fwd_a_sel = 2'b01;
    else if (a_hit_wb)           fwd_a_sel = 2'b10;
    if (b_hit_ex && !ex_slot.md) fwd_b_sel = 2'b01;
    else if (b_hit_wb)           fwd_b_sel = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot <= '0;
      wb_slot <= '0;
    end else begin
      wb_slot <= ex_slot;
      if (stall || flush) ex_slot <= '0;
      else                ex_slot <= '{valid: dof_valid, da: dof_da, rw: dof_rw, md: dof_md};
    end
  end

  // A flushed load-use never arms the counter: the consumer is gone.
  always_ff @(posedge clk) begin
    if (rst)                                        stall_cnt <= 3'd0;
    else if (hazard && (stall_cnt == 3'd0) && !flush) stall_cnt <= STALL_LOAD;
    else if (stall_cnt != 3'd0)                      stall_cnt <= stall_cnt - 3'd1;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (!stall && ((fwd_a_sel != 2'b00) || (fwd_b_sel != 2'b00)) && !(&fwd_count))
        fwd_count <= fwd_count + 1'b1;
    end
  end
`endif

endmodule
